flot_sqrt_arbiter: RTL

//  Shares one pipelined FP square-root unit (flot_Sqrt_pipe) among NREQ requesters.

---
 rtl/flot_sqrt_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/flot_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// flot_sqrt_arbiter
//
// Shares one pipelined floating-point square-root unit among NREQ requesters.
// At most one operand is issued per cycle, chosen round-robin. A tag pipe
// matched to the unit latency remembers which requester owns each in-flight
// operation, so the result can be routed back. An IDLE/RUN/DRAIN FSM sequences
// the unit's clock enable and handles flush/disable by draining the pipe.
//
// Optional feature (compile-time macro SQRT_ARB_STATS_EN):
//   adds output stat_grants, one saturating 16-bit grant counter per requester,
//   cleared by nRST and whenever flush_done pulses.
//
// Ports
//   CLK, nRST      clock (rising edge) and asynchronous active-low reset
//   en             1 = accept requests; 0 = drain then idle
//   flush          1-cycle pulse: stop issuing, drain pipe, pulse flush_done
//   req_valid      per-requester operand valid
//   req_op         operands, requester i at [i*WIDTH +: WIDTH]
//   req_exce       per-requester exception-in flag
//   req_ready      one-hot grant (transfer when valid & ready)
//   sqrt_op        operand to the sqrt unit
//   sqrt_ce        clock enable to the sqrt unit
//   sqrt_exce_in   exception-in to the sqrt unit
//   sqrt_result    result from the sqrt unit
//   sqrt_exce_out  exception-out from the sqrt unit
//   rsp_valid      one-hot owner of the result currently on rsp_result
//   rsp_result     shared result bus (sqrt_result passed through)
//   rsp_exce       shared exception bus (sqrt_exce_out passed through)
//   busy           any operation in flight, or FSM not idle
//   flush_done     1-cycle pulse when a drain (or idle flush) completes
//   stat_grants    [SQRT_ARB_STATS_EN only] per-requester grant counters
// -----------------------------------------------------------------------------
module flot_sqrt_arbiter #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_exp = 8,
  parameter int WIDTH_mat = 23,
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int PIPE_LAT  = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  en,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_op,
  input  logic [NREQ-1:0]       req_exce,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      sqrt_op,
  output logic                  sqrt_ce,
  output logic                  sqrt_exce_in,
  input  logic [WIDTH-1:0]      sqrt_result,
  input  logic                  sqrt_exce_out,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_exce,
  output logic                  busy,
  output logic                  flush_done
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    stat_grants
`endif
);

  // Elaboration-time sanity checks on the parameter set.
  if (1 + WIDTH_exp + WIDTH_mat != WIDTH) begin : g_bad_fp_fields
    $error("flot_sqrt_arbiter: WIDTH must equal 1 + WIDTH_exp + WIDTH_mat");
  end
  if ((1 << ID_W) < NREQ || NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("flot_sqrt_arbiter: NREQ must be 2..8 and fit in ID_W bits");
  end
  if (PIPE_LAT < 1) begin : g_bad_lat
    $error("flot_sqrt_arbiter: PIPE_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  tag_t            tag_q [PIPE_LAT];

  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            pipe_any;
  logic            upstream_any;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: scan ptr+1 .. ptr (wrapping), first valid wins.
  // Scanning from the far end down lets the nearest hit overwrite later ones.
  // Grants are suppressed in the cycle that leaves RUN (flush or en low).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    if (state == S_RUN && en && !flush) begin
      for (int k = NREQ; k >= 1; k--) begin
        if (req_valid[(int'(ptr) + k) % NREQ]) begin
          grant_valid = 1'b1;
          grant_id    = ID_W'((int'(ptr) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    sqrt_op      = '0;
    sqrt_exce_in = 1'b0;
    if (grant_valid) begin
      req_ready    = NREQ'(1) << grant_id;
      sqrt_op      = req_op[int'(grant_id)*WIDTH +: WIDTH];
      sqrt_exce_in = req_exce[grant_id];
    end
  end

  assign sqrt_ce = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Tag pipe: tracks owner of each in-flight op, advancing in lockstep with
  // the sqrt unit (only while its CE is high).
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the tag pipe is small and its valid bits must be cleared on
      // reset, otherwise stale in-flight ops would produce responses after
      // reset release; so every stage is reset, not just a read pointer.
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else if (sqrt_ce) begin
      // NOTE: non-blocking assignments make every stage sample the value of
      // its predecessor from before the clock edge, giving a true shift.
      tag_q[0] <= '{valid: grant_valid, id: grant_id};
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // upstream_any looks at every stage except the last: if it is clear, the
  // pipe will be empty after this cycle's shift, so the drain can complete
  // exactly one cycle after the final response.
  always_comb begin
    pipe_any     = 1'b0;
    upstream_any = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) pipe_any = pipe_any | tag_q[i].valid;
    for (int i = 0; i < PIPE_LAT - 1; i++) upstream_any = upstream_any | tag_q[i].valid;
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_q[PIPE_LAT-1].valid && sqrt_ce) rsp_valid = NREQ'(1) << tag_q[PIPE_LAT-1].id;
  end

  assign rsp_result = sqrt_result;
  assign rsp_exce   = sqrt_exce_out;
  assign busy       = pipe_any || (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Round-robin pointer: remembers the last granted requester.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)            ptr <= ID_W'(NREQ - 1);
    else if (grant_valid) ptr <= grant_id;
  end

  // ---------------------------------------------------------------------------
  // Control FSM. Flush is ignored while draining; a flush coinciding with
  // en=0 in RUN still yields a single drain and a single flush_done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= S_IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush)   flush_done <= 1'b1;
          else if (en) state      <= S_RUN;
        end
        S_RUN: begin
          if (flush || !en) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!upstream_any) begin
            flush_done <= 1'b1;
            state      <= en ? S_RUN : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SQRT_ARB_STATS_EN
  // Per-requester grant counters, saturating; cleared with each flush_done.
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (flush_done) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (grant_valid && grant_cnt[grant_id] != 16'hFFFF) begin
      grant_cnt[grant_id] <= grant_cnt[grant_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_cnt[g];
  end
`endif

endmodule
